// File: rtl/decode_stage_ctrl.sv
// Registered RV32I/M decode stage with valid/ready on both sides, MUL/DIV stall and HALT ownership.
// Optional M-extension decode and the MD_WAIT stall counter are built only when RV32M_EN is defined.
module decode_stage_ctrl #(
  parameter int unsigned MUL_LATENCY  = 2,
  parameter int unsigned DIV_LATENCY  = 32,
  parameter logic [6:0]  HALT_OPCODE  = 7'h7F,
  parameter bit          RESET_HALTED = 1'b0
) (
  input  logic        Clk,
  input  logic        Rst_N,
  input  logic        Instr_Valid,
  input  logic [31:0] Instruction,
  output logic        Instr_Ready,
  output logic        Ex_Valid,
  input  logic        Ex_Ready,
  output logic [3:0]  ALU_Opcode,
  output logic [2:0]  MUL_Opcode,
  output logic        Reg_Wr_En,
  output logic        ALU_Input_A_Sel,
  output logic        ALU_Input_B_Sel,
  output logic [1:0]  Reg_WB_Sel,
  output logic [1:0]  Imm_Gen_Sel,
  output logic [2:0]  Lw_Sw_OP,
  output logic        Store_Word_En,
  output logic        Read_Ctrl,
  output logic        Is_Branch,
  output logic [2:0]  Branch_Funct3,
  output logic        Is_Jump,
  output logic        Illegal_Instr,
  input  logic        Resume,
  output logic        Halted,
  output logic        Clk_Enable
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_M = 4'd10
  } alu_t;

`ifdef RV32M_EN
  typedef enum logic [1:0] {RUN = 2'd0, MD_WAIT = 2'd1, HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd2} state_t;
`endif

  typedef struct packed {
    alu_t       alu_op;
    logic [2:0] mul_op;
    logic       reg_wr;
    logic       a_sel;
    logic       b_sel;
    logic [1:0] wb_sel;
    logic [1:0] imm_sel;
    logic [2:0] ls_op;
    logic       st_en;
    logic       rd_en;
    logic       is_br;
    logic [2:0] br_f3;
    logic       is_jmp;
  } ctrl_t;

  state_t     state;
  ctrl_t      ex_q;
  ctrl_t      dec;
  logic       ex_valid_q;
  logic       illegal_q;
  logic       halted_q;
  logic       clk_en_q;
  logic       dec_illegal;
  logic       dec_halt;
  logic       dec_mop;
  logic       accept;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr_bits;

  assign opcode = Instruction[6:0];
  assign funct3 = Instruction[14:12];
  assign unused_instr_bits = ^{Instruction[31], Instruction[29:26], Instruction[24:15], Instruction[11:7]};

  assign Instr_Ready = (state == RUN) && (!ex_valid_q || Ex_Ready);
  assign accept      = Instr_Valid && Instr_Ready;

  function automatic alu_t alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_from_f3 = ALU_SLL;
      3'd2:    alu_from_f3 = ALU_SLT;
      3'd3:    alu_from_f3 = ALU_SLTU;
      3'd4:    alu_from_f3 = ALU_XOR;
      3'd5:    alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    dec_halt    = 1'b0;
    dec_mop     = 1'b0;
    if (opcode == HALT_OPCODE) begin
      dec_halt = 1'b1;
    end else begin
      case (opcode)
        OP_LUI: begin
          dec.reg_wr = 1'b1; dec.b_sel = 1'b1; dec.wb_sel = 2'b01; dec.imm_sel = 2'b11;
        end
        OP_AUIPC: begin
          dec.reg_wr = 1'b1; dec.a_sel = 1'b1; dec.b_sel = 1'b1;
          dec.wb_sel = 2'b01; dec.imm_sel = 2'b11;
        end
        OP_JAL: begin
          dec.reg_wr = 1'b1; dec.a_sel = 1'b1; dec.b_sel = 1'b1;
          dec.wb_sel = 2'b10; dec.imm_sel = 2'b11; dec.is_jmp = 1'b1;
        end
        OP_JALR: begin
          dec.reg_wr = 1'b1; dec.b_sel = 1'b1; dec.wb_sel = 2'b10; dec.is_jmp = 1'b1;
        end
        OP_BRANCH: begin
          dec.a_sel = 1'b1; dec.b_sel = 1'b1; dec.imm_sel = 2'b10;
          dec.is_br = 1'b1; dec.br_f3 = funct3;
        end
        OP_LOAD: begin
          dec.reg_wr = 1'b1; dec.b_sel = 1'b1; dec.rd_en = 1'b1;
          case (funct3)
            3'd0:    dec.ls_op = 3'd0;
            3'd1:    dec.ls_op = 3'd1;
            3'd2:    dec.ls_op = 3'd2;
            3'd4:    dec.ls_op = 3'd3;
            3'd5:    dec.ls_op = 3'd4;
            default: dec_illegal = 1'b1;
          endcase
        end
        OP_STORE: begin
          dec.b_sel = 1'b1; dec.imm_sel = 2'b01; dec.st_en = 1'b1;
          dec.ls_op = 3'd5 + funct3;
          if (funct3 > 3'd2) dec_illegal = 1'b1;
        end
        OP_IMM: begin
          dec.reg_wr = 1'b1; dec.b_sel = 1'b1; dec.wb_sel = 2'b01;
          // bit 30 only selects SRAI; for ADDI it is part of the immediate
          dec.alu_op = alu_from_f3(funct3, (funct3 == 3'd5) && Instruction[30]);
        end
        OP_REG: begin
          dec.reg_wr = 1'b1; dec.wb_sel = 2'b01;
          if (Instruction[25]) begin
`ifdef RV32M_EN
            dec.alu_op = ALU_M;
            dec.mul_op = funct3;
            dec_mop    = 1'b1;
`else
            dec_illegal = 1'b1;
`endif
          end else begin
            dec.alu_op = alu_from_f3(funct3, Instruction[30]);
          end
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

`ifdef RV32M_EN
  localparam int unsigned LAT_MAX = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int unsigned CNT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX + 1);

  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] md_lat;

  assign md_lat = funct3[2] ? CNT_W'(DIV_LATENCY) : CNT_W'(MUL_LATENCY);
`endif

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state      <= RESET_HALTED ? HALT : RUN;
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      halted_q   <= RESET_HALTED;
      clk_en_q   <= !RESET_HALTED;
`ifdef RV32M_EN
      md_cnt     <= '0;
`endif
    end else begin
      illegal_q <= 1'b0;
      if (accept) begin
        if (dec_illegal) begin
          illegal_q  <= 1'b1;
          ex_valid_q <= 1'b0;
        end else if (dec_halt) begin
          ex_valid_q <= 1'b0;
          state      <= HALT;
          halted_q   <= 1'b1;
          clk_en_q   <= 1'b0;
        end else begin
          ex_q       <= dec;
          ex_valid_q <= 1'b1;
`ifdef RV32M_EN
          if (dec_mop && (md_lat != '0)) begin
            state  <= MD_WAIT;
            md_cnt <= md_lat;
          end
`endif
        end
      end else if (Ex_Ready) begin
        ex_valid_q <= 1'b0;
      end

      case (state)
`ifdef RV32M_EN
        MD_WAIT: begin
          md_cnt <= md_cnt - CNT_W'(1);
          if (md_cnt == CNT_W'(1)) state <= RUN;
        end
`endif
        HALT: begin
          if (Resume) begin
            state    <= RUN;
            halted_q <= 1'b0;
            clk_en_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Ex_Valid        = ex_valid_q;
  assign ALU_Opcode      = ex_q.alu_op;
  assign MUL_Opcode      = ex_q.mul_op;
  assign Reg_Wr_En       = ex_q.reg_wr;
  assign ALU_Input_A_Sel = ex_q.a_sel;
  assign ALU_Input_B_Sel = ex_q.b_sel;
  assign Reg_WB_Sel      = ex_q.wb_sel;
  assign Imm_Gen_Sel     = ex_q.imm_sel;
  assign Lw_Sw_OP        = ex_q.ls_op;
  assign Store_Word_En   = ex_q.st_en;
  assign Read_Ctrl       = ex_q.rd_en;
  assign Is_Branch       = ex_q.is_br;
  assign Branch_Funct3   = ex_q.br_f3;
  assign Is_Jump         = ex_q.is_jmp;
  assign Illegal_Instr   = illegal_q;
  assign Halted          = halted_q;
  assign Clk_Enable      = clk_en_q;

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Scoreboard bench for decode_stage_ctrl: random and directed instruction streams checked
// against a rule-level reference model; works with RV32M_EN defined or undefined.
module tb_decode_stage_ctrl;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned DIV_LAT = 32;
  localparam int K_ISSUE = 0, K_ILL = 1, K_HALT = 2;
  localparam int ALU_TAB[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  localparam int LD_TAB[8]  = '{0, 1, 2, -1, 3, 4, -1, -1};

  typedef struct packed {
    logic [3:0] alu;
    logic [2:0] mul;
    logic       wr;
    logic       a;
    logic       b;
    logic [1:0] wb;
    logic [1:0] imm;
    logic [2:0] ls;
    logic       st;
    logic       rd;
    logic       br;
    logic [2:0] bf3;
    logic       jmp;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst_N;
  logic        Instr_Valid;
  logic [31:0] Instruction;
  logic        Instr_Ready;
  logic        Ex_Valid;
  logic        Ex_Ready;
  logic [3:0]  ALU_Opcode;
  logic [2:0]  MUL_Opcode;
  logic        Reg_Wr_En;
  logic        ALU_Input_A_Sel;
  logic        ALU_Input_B_Sel;
  logic [1:0]  Reg_WB_Sel;
  logic [1:0]  Imm_Gen_Sel;
  logic [2:0]  Lw_Sw_OP;
  logic        Store_Word_En;
  logic        Read_Ctrl;
  logic        Is_Branch;
  logic [2:0]  Branch_Funct3;
  logic        Is_Jump;
  logic        Illegal_Instr;
  logic        Resume;
  logic        Halted;
  logic        Clk_Enable;

  always #5 Clk = ~Clk;

  decode_stage_ctrl #(
    .MUL_LATENCY (MUL_LAT),
    .DIV_LATENCY (DIV_LAT),
    .HALT_OPCODE (7'h7F),
    .RESET_HALTED(1'b0)
  ) dut (
    .Clk(Clk), .Rst_N(Rst_N), .Instr_Valid(Instr_Valid), .Instruction(Instruction),
    .Instr_Ready(Instr_Ready), .Ex_Valid(Ex_Valid), .Ex_Ready(Ex_Ready),
    .ALU_Opcode(ALU_Opcode), .MUL_Opcode(MUL_Opcode), .Reg_Wr_En(Reg_Wr_En),
    .ALU_Input_A_Sel(ALU_Input_A_Sel), .ALU_Input_B_Sel(ALU_Input_B_Sel),
    .Reg_WB_Sel(Reg_WB_Sel), .Imm_Gen_Sel(Imm_Gen_Sel), .Lw_Sw_OP(Lw_Sw_OP),
    .Store_Word_En(Store_Word_En), .Read_Ctrl(Read_Ctrl), .Is_Branch(Is_Branch),
    .Branch_Funct3(Branch_Funct3), .Is_Jump(Is_Jump), .Illegal_Instr(Illegal_Instr),
    .Resume(Resume), .Halted(Halted), .Clk_Enable(Clk_Enable)
  );

  exp_t       exp_q[$];
  logic [2:0] stat_q[$];
  int         total = 0;
  int         bad   = 0;
  bit         in_reset = 1'b1;
  bit         m_halted;
  bit         m_exv;
  int         m_stall;

  function automatic exp_t dut_fields();
    dut_fields = {ALU_Opcode, MUL_Opcode, Reg_Wr_En, ALU_Input_A_Sel, ALU_Input_B_Sel,
                  Reg_WB_Sel, Imm_Gen_Sel, Lw_Sw_OP, Store_Word_En, Read_Ctrl,
                  Is_Branch, Branch_Funct3, Is_Jump};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [31:0] w, output exp_t e, output int kind,
                                     output int mlat);
    logic [2:0] f3;
    f3   = w[14:12];
    e    = '0;
    kind = K_ISSUE;
    mlat = 0;
    if (w[6:0] == 7'h7F) kind = K_HALT;
    else case (w[6:0])
      7'h37: begin e.wr = 1; e.b = 1; e.wb = 2'd1; e.imm = 2'd3; end
      7'h17: begin e.wr = 1; e.a = 1; e.b = 1; e.wb = 2'd1; e.imm = 2'd3; end
      7'h6F: begin e.wr = 1; e.a = 1; e.b = 1; e.wb = 2'd2; e.imm = 2'd3; e.jmp = 1; end
      7'h67: begin e.wr = 1; e.b = 1; e.wb = 2'd2; e.jmp = 1; end
      7'h63: begin e.a = 1; e.b = 1; e.imm = 2'd2; e.br = 1; e.bf3 = f3; end
      7'h03: begin
        if (LD_TAB[f3] < 0) kind = K_ILL;
        else begin e.wr = 1; e.b = 1; e.rd = 1; e.ls = 3'(LD_TAB[f3]); end
      end
      7'h23: begin
        if (f3 > 3'd2) kind = K_ILL;
        else begin e.b = 1; e.imm = 2'd1; e.st = 1; e.ls = 3'(5 + int'(f3)); end
      end
      7'h13: begin
        e.wr = 1; e.b = 1; e.wb = 2'd1;
        e.alu = (f3 == 3'd5 && w[30]) ? 4'd7 : 4'(ALU_TAB[f3]);
      end
      7'h33: begin
        if (w[25]) begin
`ifdef RV32M_EN
          e.wr = 1; e.wb = 2'd1; e.alu = 4'd10; e.mul = f3;
          mlat = f3[2] ? int'(DIV_LAT) : int'(MUL_LAT);
`else
          kind = K_ILL;
`endif
        end else begin
          e.wr = 1; e.wb = 2'd1;
          if (w[30] && f3 == 3'd0) e.alu = 4'd1;
          else if (w[30] && f3 == 3'd5) e.alu = 4'd7;
          else e.alu = 4'(ALU_TAB[f3]);
        end
      end
      default: kind = K_ILL;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [10];
    int          sel;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0B};
    w   = $urandom();
    sel = int'($urandom_range(0, 59));
    if (sel == 0) w[6:0] = 7'h7F;
    else if (sel == 1) w[6:0] = 7'h5B;
    else w[6:0] = ops[sel % 10];
    if (w[6:0] == 7'h33) begin
      case ($urandom_range(0, 2))
        0:       w[31:25] = 7'h00;
        1:       w[31:25] = 7'h20;
        default: w[31:25] = 7'h01;
      endcase
    end
    return w;
  endfunction

  task automatic model_reset();
    m_halted = 1'b0;
    m_exv    = 1'b0;
    m_stall  = 0;
  endtask

  // One clock of stimulus: drive at negedge, predict ready, update the model at posedge.
  task automatic cycle(input logic iv, input logic [31:0] w, input logic exr, input logic res);
    exp_t e;
    int   kind;
    int   mlat;
    bit   rdy;
    bit   acc;
    bit   ill;
    @(negedge Clk);
    Instr_Valid = iv;
    Instruction = w;
    Ex_Ready    = exr;
    Resume      = res;
    #1;
    rdy = !m_halted && (m_stall == 0) && (!m_exv || exr);
    check("instr_ready", 64'(Instr_Ready), 64'(rdy));
    acc = iv && rdy;
    ref_decode(w, e, kind, mlat);
    @(posedge Clk);
    ill = 1'b0;
    if (m_stall > 0) m_stall--;
    if (m_halted && res) m_halted = 1'b0;
    if (m_exv && exr) m_exv = 1'b0;
    if (acc) begin
      if (kind == K_ILL) ill = 1'b1;
      else if (kind == K_HALT) m_halted = 1'b1;
      else begin
        m_exv = 1'b1;
        exp_q.push_back(e);
        m_stall = mlat;
      end
    end
    stat_q.push_back({ill, m_halted, !m_halted});
  endtask

  task automatic check_reset_values();
    check("rst_instr_ready", 64'(Instr_Ready), 64'd1);
    check("rst_clk_enable", 64'(Clk_Enable), 64'd1);
    check("rst_outputs", 64'({dut_fields(), Ex_Valid, Illegal_Instr, Halted}), 64'd0);
  endtask

  initial begin : monitor
    logic [2:0] st;
    forever begin
      @(negedge Clk);
      #2;
      if (in_reset) continue;
      if (stat_q.size() != 0) begin
        st = stat_q.pop_front();
        check("status_ill_halt_clken", 64'({Illegal_Instr, Halted, Clk_Enable}), 64'(st));
      end
      check("ex_valid", 64'(Ex_Valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0 && Ex_Valid) begin
        check("ex_fields", 64'(dut_fields()), 64'(exp_q[0]));
        if (Ex_Ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin : stimulus
    Rst_N       = 1'b0;
    Instr_Valid = 1'b0;
    Instruction = '0;
    Ex_Ready    = 1'b0;
    Resume      = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);
    #1;
    check_reset_values();
    @(negedge Clk);
    Rst_N    = 1'b1;
    in_reset = 1'b0;

    cycle(1, 32'h002081B3, 1, 0);
    cycle(0, 32'h0, 1, 0);

    cycle(1, 32'h00012083, 1, 0);
    repeat (3) cycle(1, 32'h00112223, 0, 0);
    cycle(1, 32'h00112223, 1, 0);
    cycle(0, 32'h0, 1, 0);

    cycle(1, 32'h0220C1B3, 1, 0);
    repeat (36) cycle(1, 32'h002081B3, 1, 0);

    cycle(1, 32'h0000007F, 1, 0);
    repeat (2) cycle(1, 32'h002081B3, 1, 0);
    cycle(0, 32'h0, 1, 1);
    cycle(1, 32'h002081B3, 1, 0);

    cycle(1, 32'h0000000B, 1, 0);
    cycle(1, 32'h0000B083, 1, 0);
    cycle(1, 32'h002081B3, 1, 0);
    cycle(0, 32'h0, 1, 0);

    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0));
    end
    repeat (40) cycle(0, 32'h0, 1, 1);

    cycle(1, 32'h0220C1B3, 1, 0);
    repeat (5) cycle(0, 32'h0, 0, 0);
    @(negedge Clk);
    in_reset = 1'b1;
    Rst_N    = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    stat_q.delete();
    model_reset();
    @(negedge Clk);
    Rst_N    = 1'b1;
    in_reset = 1'b0;
    cycle(1, 32'h002081B3, 1, 0);
    repeat (3) cycle(0, 32'h0, 1, 0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
